fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction buffer between the fetch stage and decode. Captures {instruction, PC, PC+4} for each fetched address and presents them in order to decode with a valid/ready handshake.
- Decouples decode stalls from the PC register and discards all buffered instructions when a redirect (PCSrcW) is taken in writeback.

Parameters:
- WIDTH, 8, PC/address width; must match the fetch stage.
- INSTR_W, 32, instruction word width.
- DEPTH, 4, number of entries; power of 2, at least 2.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low reset (0 = reset at the next clk edge).
- PCSrcW  in  1  redirect/flush from writeback; same signal that steers the fetch PC mux.
- PCF  in  WIDTH  current fetch PC.
- PCPlus4F  in  WIDTH  PCF + 4 from fetch.
- InstrF  in  INSTR_W  instruction memory read data for PCF (combinational read).
- ValidF  in  1  fetch offers {InstrF, PCF, PCPlus4F} this cycle.
- ReadyF  out  1  queue can accept; equals !full.
- StallF  out  1  equals !ReadyF; drives the PC register hold.
- InstrD  out  INSTR_W  head instruction; 0 when empty.
- PCD  out  WIDTH  head PC; 0 when empty.
- PCPlus4D  out  WIDTH  head PC+4; 0 when empty.
- ValidD  out  1  head entry present (count != 0).
- ReadyD  in  1  decode consumes head this cycle.
- Count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Storage: circular buffer with read pointer, write pointer and count. Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Reset (reset==0 at a clk edge):
  - Pointers and Count are set to 0.
  - ValidD=0, InstrD/PCD/PCPlus4D=0, ReadyF=1, StallF=0.
  - Storage contents are not cleared.
  - Reset takes priority over everything, including PCSrcW and any transfer in flight.
- Enqueue occurs when ValidF && ReadyF.
  - The entry is written at the write pointer, which then advances.
  - The entry becomes visible at the outputs the next cycle. Latency is 1 cycle; there is no same-cycle bypass when empty.
- Dequeue occurs when ValidD && ReadyD. The read pointer advances. The outputs are driven combinationally from the head entry, masked to 0 when Count==0.
- Simultaneous enqueue and dequeue:
  - Both pointers advance and Count is unchanged.
  - When full, ReadyF=0, so no enqueue happens even if a dequeue happens the same cycle. There is no full pass-through.
- Flush (PCSrcW==1, reset==1):
  - Next state: both pointers=0 and Count=0.
  - Any enqueue or dequeue that cycle is discarded. The PCF presented that cycle is the stale path.
  - Decode must ignore ValidD in the flush cycle; the pipeline control squashes it.
  - ReadyF=1 on the following cycle.
- Count stays in the range 0..DEPTH. The implementation must assert that it never overflows or underflows.
- Width rules: all address fields are WIDTH bits. There is no arithmetic on PCs inside this block.

Decomposition:
- Package fetch_pkg:
  - default constants PC_WIDTH=8, INSTR_WIDTH=32, FQ_DEPTH=4;
  - NOP_INSTR=0;
  - typedef fq_state_t {EMPTY, PARTIAL, FULL}, used for coverage and assertions only.
- Sub-module fq_storage (DEPTH x (INSTR_W+2*WIDTH) register array):
  - synchronous write on we;
  - asynchronous read by read address;
  - no reset.
- fetch_queue holds pointers, Count, flush/handshake logic and output masking.

Test Plan:
- Reset hold: reset=0 for 2 cycles with ValidF=1 -> Count=0, ValidD=0, ReadyF=1, all D outputs 0.
- Fill to full: ReadyD=0, enqueue PCF=0x00,0x04,0x08,0x0C with InstrF=0xA0..0xA3 -> Count=4, ReadyF=0, StallF=1. A 5th offer (PCF=0x10) is not accepted; head shows PCD=0x00, InstrD=0xA0, PCPlus4D=0x04.
- Drain order: from full, ReadyD=1, ValidF=0 for 4 cycles -> PCD sequence 0x00,0x04,0x08,0x0C. Then ValidD=0, outputs 0, Count=0.
- Streaming and wrap: ValidF=ReadyD=1 for 10 cycles with PCF=0x00..0x24 step 4 -> Count steady at 1 after the first cycle. PCD trails PCF by exactly 1 cycle; pointers wrap without loss.
- Flush: Count=3 and PCSrcW=1 with ValidF=1, PCF=0x30 -> next cycle Count=0, ValidD=0; 0x30 is not captured. Then enqueue PCF=0x80 -> PCD=0x80 one cycle later.
- Reset mid-operation: Count=2, reset=0 for one cycle during simultaneous enqueue and dequeue -> Count=0, ValidD=0. A subsequent enqueue of 0x40 appears as the head.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch-to-decode instruction queue.
package fetch_pkg;

    localparam int PC_WIDTH    = 8;
    localparam int INSTR_WIDTH = 32;
    localparam int FQ_DEPTH    = 4;

    localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = '0;

    // Occupancy class; only observed by assertions and coverage.
    typedef enum logic [1:0] {
        EMPTY,
        PARTIAL,
        FULL
    } fq_state_t;

endpackage

// File: rtl/fq_storage.sv
// Entry array for fetch_queue: synchronous write, asynchronous read, no reset.
module fq_storage #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 48
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: {instr, PC, PC+4} entries in a
// circular buffer with valid/ready handshakes and a writeback-driven flush.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int WIDTH   = PC_WIDTH,
    parameter int INSTR_W = INSTR_WIDTH,
    parameter int DEPTH   = FQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       PCSrcW,
    input  logic [WIDTH-1:0]           PCF,
    input  logic [WIDTH-1:0]           PCPlus4F,
    input  logic [INSTR_W-1:0]         InstrF,
    input  logic                       ValidF,
    output logic                       ReadyF,
    output logic                       StallF,
    output logic [INSTR_W-1:0]         InstrD,
    output logic [WIDTH-1:0]           PCD,
    output logic [WIDTH-1:0]           PCPlus4D,
    output logic                       ValidD,
    input  logic                       ReadyD,
    output logic [$clog2(DEPTH):0]     Count
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int DATA_W = INSTR_W + 2 * WIDTH;

    localparam logic [PTR_W-1:0] PTR_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [PTR_W-1:0]  rptr;
    logic [PTR_W-1:0]  wptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] head;
    logic              enq;
    logic              deq;
    logic              write_en;
    fq_state_t         state;

    assign ReadyF = (count != CNT_FULL);
    assign StallF = ~ReadyF;
    assign ValidD = (count != '0);
    assign Count  = count;

    assign enq = ValidF && ReadyF;
    assign deq = ValidD && ReadyD;
    // A flushed or reset cycle must not leave a stale-path entry behind.
    assign write_en = enq && reset && !PCSrcW;

    fq_storage #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_storage (
        .clk   (clk),
        .we    (write_en),
        .waddr (wptr),
        .wdata ({InstrF, PCF, PCPlus4F}),
        .raddr (rptr),
        .rdata (head)
    );

    always_ff @(posedge clk) begin
        if (!reset || PCSrcW) begin
            rptr  <= '0;
            wptr  <= '0;
            count <= '0;
        end else begin
            if (enq) begin
                wptr <= wptr + PTR_ONE;
            end
            if (deq) begin
                rptr <= rptr + PTR_ONE;
            end
            case ({enq, deq})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        InstrD   = INSTR_W'(NOP_INSTR);
        PCD      = '0;
        PCPlus4D = '0;
        if (ValidD) begin
            {InstrD, PCD, PCPlus4D} = head;
        end
    end

    always_comb begin
        state = PARTIAL;
        if (count == '0) begin
            state = EMPTY;
        end else if (count == CNT_FULL) begin
            state = FULL;
        end
    end

    // Count is unsigned, so an underflow would wrap above DEPTH and trip this too.
    a_count_range: assert property (@(posedge clk) disable iff (!reset)
        count <= CNT_FULL);
    a_no_underflow: assert property (@(posedge clk) disable iff (!reset)
        deq |-> (count != '0));
    a_full_stalls: assert property (@(posedge clk) disable iff (!reset)
        (state == FULL) |-> (StallF && !ReadyF));
    a_empty_invalid: assert property (@(posedge clk) disable iff (!reset)
        (state == EMPTY) |-> !ValidD);

    c_full:  cover property (@(posedge clk) state == FULL);
    c_empty: cover property (@(posedge clk) state == EMPTY);

endmodule

// File: tb/tb_fetch_queue.sv
// Randomized and directed checks of fetch_queue against a queue-based model.
module tb_fetch_queue;

    localparam int WIDTH   = 8;
    localparam int INSTR_W = 32;
    localparam int DEPTH   = 4;
    localparam int CNT_W   = $clog2(DEPTH) + 1;

    typedef struct {
        logic [INSTR_W-1:0] instr;
        logic [WIDTH-1:0]   pc;
        logic [WIDTH-1:0]   pc4;
    } entry_t;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               PCSrcW = 1'b0;
    logic [WIDTH-1:0]   PCF = '0;
    logic [WIDTH-1:0]   PCPlus4F = '0;
    logic [INSTR_W-1:0] InstrF = '0;
    logic               ValidF = 1'b0;
    logic               ReadyF;
    logic               StallF;
    logic [INSTR_W-1:0] InstrD;
    logic [WIDTH-1:0]   PCD;
    logic [WIDTH-1:0]   PCPlus4D;
    logic               ValidD;
    logic               ReadyD = 1'b0;
    logic [CNT_W-1:0]   Count;

    int unsigned checks = 0;
    int unsigned failures = 0;
    entry_t      model_q[$];

    fetch_queue #(
        .WIDTH   (WIDTH),
        .INSTR_W (INSTR_W),
        .DEPTH   (DEPTH)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .PCSrcW   (PCSrcW),
        .PCF      (PCF),
        .PCPlus4F (PCPlus4F),
        .InstrF   (InstrF),
        .ValidF   (ValidF),
        .ReadyF   (ReadyF),
        .StallF   (StallF),
        .InstrD   (InstrD),
        .PCD      (PCD),
        .PCPlus4D (PCPlus4D),
        .ValidD   (ValidD),
        .ReadyD   (ReadyD),
        .Count    (Count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Compare every DUT output with what the model queue implies.
    task automatic check_all();
        entry_t h;
        bit     has;
        has = (model_q.size() != 0);
        h = '{instr: '0, pc: '0, pc4: '0};
        if (has) h = model_q[0];
        check_eq("count",    64'(Count),    64'(model_q.size()));
        check_eq("valid_d",  64'(ValidD),   64'(has));
        check_eq("ready_f",  64'(ReadyF),   64'(model_q.size() < DEPTH));
        check_eq("stall_f",  64'(StallF),   64'(model_q.size() >= DEPTH));
        check_eq("instr_d",  64'(InstrD),   64'(h.instr));
        check_eq("pc_d",     64'(PCD),      64'(h.pc));
        check_eq("pc4_d",    64'(PCPlus4D), 64'(h.pc4));
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check after it.
    task automatic step(input logic rst_n, input logic flush, input logic vf,
                        input logic [WIDTH-1:0] pc, input logic [INSTR_W-1:0] instr,
                        input logic rd);
        bit can_enq;
        bit can_deq;
        reset    = rst_n;
        PCSrcW   = flush;
        ValidF   = vf;
        PCF      = pc;
        PCPlus4F = pc + 8'd4;
        InstrF   = instr;
        ReadyD   = rd;
        @(posedge clk);
        if (!rst_n || flush) begin
            model_q.delete();
        end else begin
            can_enq = vf && (model_q.size() < DEPTH);
            can_deq = rd && (model_q.size() > 0);
            if (can_deq) void'(model_q.pop_front());
            if (can_enq) model_q.push_back('{instr: instr, pc: pc, pc4: pc + 8'd4});
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        // Reset hold with a pending offer.
        step(1'b0, 1'b0, 1'b1, 8'h20, 32'hDEAD, 1'b0);
        step(1'b0, 1'b0, 1'b1, 8'h24, 32'hBEEF, 1'b0);
        check_eq("rst_count", 64'(Count),  64'd0);
        check_eq("rst_ready", 64'(ReadyF), 64'd1);
        check_eq("rst_pcd",   64'(PCD),    64'd0);

        // Fill to full, then a refused fifth offer.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'(i * 4), 32'hA0 + 32'(i), 1'b0);
        end
        step(1'b1, 1'b0, 1'b1, 8'h10, 32'hA4, 1'b0);
        check_eq("full_count", 64'(Count),    64'd4);
        check_eq("full_stall", 64'(StallF),   64'd1);
        check_eq("full_ready", 64'(ReadyF),   64'd0);
        check_eq("full_instr", 64'(InstrD),   64'hA0);
        check_eq("full_pcd",   64'(PCD),      64'h00);
        check_eq("full_pc4d",  64'(PCPlus4D), 64'h04);

        // Drain in order.
        for (int i = 0; i < 4; i++) begin
            check_eq("drain_pcd", 64'(PCD), 64'(i * 4));
            step(1'b1, 1'b0, 1'b0, 8'hFF, 32'h0, 1'b1);
        end
        check_eq("drain_valid", 64'(ValidD), 64'd0);
        check_eq("drain_instr", 64'(InstrD), 64'd0);

        // Streaming across pointer wrap: PCD trails PCF by one cycle.
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'(i * 4), 32'h100 + 32'(i), 1'b1);
            check_eq("stream_count", 64'(Count), 64'd1);
            check_eq("stream_pcd",   64'(PCD),   64'(i * 4));
        end

        // Flush with three entries and a stale-path offer.
        step(1'b0, 1'b0, 1'b0, 8'h0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, 1'b1, 8'h50 + 8'(i * 4), 32'hC0 + 32'(i), 1'b0);
        end
        check_eq("pre_flush_count", 64'(Count), 64'd3);
        step(1'b1, 1'b1, 1'b1, 8'h30, 32'h30, 1'b1);
        check_eq("flush_count", 64'(Count),  64'd0);
        check_eq("flush_valid", 64'(ValidD), 64'd0);
        step(1'b1, 1'b0, 1'b1, 8'h80, 32'h880, 1'b0);
        check_eq("post_flush_pcd", 64'(PCD), 64'h80);

        // Reset mid-operation during simultaneous enqueue and dequeue.
        step(1'b1, 1'b0, 1'b1, 8'h84, 32'h884, 1'b0);
        check_eq("pre_rst_count", 64'(Count), 64'd2);
        step(1'b0, 1'b0, 1'b1, 8'h88, 32'h888, 1'b1);
        check_eq("mid_rst_count", 64'(Count),  64'd0);
        check_eq("mid_rst_valid", 64'(ValidD), 64'd0);
        step(1'b1, 1'b0, 1'b1, 8'h40, 32'h440, 1'b0);
        check_eq("post_rst_pcd",   64'(PCD),    64'h40);
        check_eq("post_rst_instr", 64'(InstrD), 64'h440);

        // Randomized traffic with occasional flushes and resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 11) == 0),
                 ($urandom_range(0, 3) != 0),
                 8'($urandom_range(0, 63) * 4),
                 32'($urandom),
                 ($urandom_range(0, 1) == 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
